// File: rtl/operand_sweep_checker.sv
// operand_sweep_checker
//   Exhaustive operand sweep engine for the micro CPU. For every pair (a, b)
//   it holds the CPU in reset, writes a and b into data RAM, releases the CPU,
//   waits for the program counter to reach DONE_ADDR, then reads the result
//   back and compares it to a golden value for the latched ALU mode.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, mode           sweep request (accepted only in IDLE, mode != 7)
//   rom_addr              CPU program counter
//   cpu_ram_*             CPU-side RAM port (passed through while cpu_rst=0)
//   ram_rd_data           RAM read data (combinational)
//   cpu_rst               registered reset to the CPU
//   ram_*                 muxed RAM port
//   busy, done, mismatch  status; done/mismatch are one-cycle pulses
//   last_a, last_b        operands of the most recently checked pair
//   ok/err/timeout_count  saturating result counters
module operand_sweep_checker #(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 8,
    parameter int DONE_ADDR = 'h87,
    parameter int OPA_ADDR  = 0,
    parameter int OPB_ADDR  = 1,
    parameter int RES_ADDR  = 2,
    parameter int TIMEOUT   = 4096,
    parameter int CNT_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [ADDR_W-1:0] cpu_ram_addr,
    input  logic [WIDTH-1:0]  cpu_ram_wr_data,
    input  logic              cpu_ram_wr_en,
    input  logic [WIDTH-1:0]  ram_rd_data,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wr_data,
    output logic              ram_wr_en,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [WIDTH-1:0]  last_a,
    output logic [WIDTH-1:0]  last_b,
    output logic [CNT_W-1:0]  ok_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  timeout_count
);

    localparam logic [ADDR_W-1:0] DONE_A   = ADDR_W'(DONE_ADDR);
    localparam logic [ADDR_W-1:0] OPA_A    = ADDR_W'(OPA_ADDR);
    localparam logic [ADDR_W-1:0] OPB_A    = ADDR_W'(OPB_ADDR);
    localparam logic [ADDR_W-1:0] RES_LO_A = ADDR_W'(RES_ADDR);
    localparam logic [ADDR_W-1:0] RES_HI_A = ADDR_W'(RES_ADDR + 1);
    localparam int                TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_RUN, S_WAIT, S_READ_LO,
        S_READ_HI, S_CHECK, S_NEXT, S_FINISH
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        mode_q;
    logic [WIDTH-1:0]  a, b, res_lo, res_hi;
    logic [TMR_W-1:0]  timer;
    logic              accept, hit, tmo, pass;
    logic [ADDR_W-1:0] fsm_addr;
    logic [WIDTH-1:0]  fsm_data;
    logic              fsm_we;
    logic [WIDTH-1:0]  gold_lo;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept = start && (mode != 3'd7);
    assign hit    = (rom_addr == DONE_A);
    assign tmo    = (timer == TMR_LAST);

    // Golden result for the latched mode
    always_comb begin
        prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        gold_lo = '0;
        case (mode_q)
            3'd0:    gold_lo = a + b;
            3'd1:    gold_lo = a - b;
            3'd2:    gold_lo = ~(a & b);
            3'd3:    gold_lo = ~(a | b);
            3'd4:    gold_lo = a ^ b;
            3'd5:    gold_lo = ~(a ^ b);
            default: gold_lo = '0;
        endcase
        pass = (mode_q == 3'd6) ? ({res_hi, res_lo} == prod) : (res_lo == gold_lo);
    end

    // Next state and the FSM side of the RAM port
    always_comb begin
        state_nxt = state;
        fsm_addr  = '0;
        fsm_data  = '0;
        fsm_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (accept) state_nxt = S_LOAD_A;
            end
            S_LOAD_A: begin
                fsm_addr  = OPA_A;
                fsm_data  = a;
                fsm_we    = 1'b1;
                state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                fsm_addr  = OPB_A;
                fsm_data  = b;
                fsm_we    = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: state_nxt = S_WAIT;
            S_WAIT: begin
                // done takes priority over a coincident timeout
                if (hit)      state_nxt = S_READ_LO;
                else if (tmo) state_nxt = S_NEXT;
            end
            S_READ_LO: begin
                fsm_addr  = RES_LO_A;
                state_nxt = (mode_q == 3'd6) ? S_READ_HI : S_CHECK;
            end
            S_READ_HI: begin
                fsm_addr  = RES_HI_A;
                state_nxt = S_CHECK;
            end
            S_CHECK: state_nxt = S_NEXT;
            S_NEXT:  state_nxt = ((&a) && (&b)) ? S_FINISH : S_LOAD_A;
            S_FINISH: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The CPU owns the RAM whenever it is out of reset
    assign ram_addr    = cpu_rst ? fsm_addr : cpu_ram_addr;
    assign ram_wr_data = cpu_rst ? fsm_data : cpu_ram_wr_data;
    assign ram_wr_en   = cpu_rst ? fsm_we   : cpu_ram_wr_en;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst       <= 1'b1;
            mismatch      <= 1'b0;
            mode_q        <= '0;
            a             <= '0;
            b             <= '0;
            res_lo        <= '0;
            res_hi        <= '0;
            timer         <= '0;
            last_a        <= '0;
            last_b        <= '0;
            ok_count      <= '0;
            err_count     <= '0;
            timeout_count <= '0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode_q        <= mode;
                        a             <= '0;
                        b             <= '0;
                        ok_count      <= '0;
                        err_count     <= '0;
                        timeout_count <= '0;
                    end
                end
                S_RUN: begin
                    cpu_rst <= 1'b0;
                    timer   <= '0;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (hit) begin
                        cpu_rst <= 1'b1;
                    end else if (tmo) begin
                        cpu_rst       <= 1'b1;
                        err_count     <= sat_inc(err_count);
                        timeout_count <= sat_inc(timeout_count);
                        mismatch      <= 1'b1;
                        last_a        <= a;
                        last_b        <= b;
                    end
                end
                S_READ_LO: res_lo <= ram_rd_data;
                S_READ_HI: res_hi <= ram_rd_data;
                S_CHECK: begin
                    if (pass) begin
                        ok_count <= sat_inc(ok_count);
                    end else begin
                        err_count <= sat_inc(err_count);
                        mismatch  <= 1'b1;
                    end
                    last_a <= a;
                    last_b <= b;
                end
                S_NEXT: begin
                    a <= a + 1'b1;
                    if (&a) b <= b + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_sweep_checker.sv
// Directed bench for operand_sweep_checker at WIDTH=2 (16 pairs per sweep),
// with a behavioural RAM and a CPU stub that writes a selectable result.
module tb_operand_sweep_checker;

    localparam int W  = 2;
    localparam int AW = 8;
    localparam int CW = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [2:0]    mode;
    logic [AW-1:0] rom_addr, cpu_ram_addr, ram_addr;
    logic [W-1:0]  cpu_ram_wr_data, ram_rd_data, ram_wr_data;
    logic          cpu_ram_wr_en, cpu_rst, ram_wr_en, busy, done, mismatch;
    logic [W-1:0]  last_a, last_b;
    logic [CW-1:0] ok_count, err_count, timeout_count;

    int checks = 0;
    int errors = 0;

    operand_sweep_checker #(
        .WIDTH(W), .ADDR_W(AW), .DONE_ADDR('h87), .OPA_ADDR(0), .OPB_ADDR(1),
        .RES_ADDR(2), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .rom_addr(rom_addr),
        .cpu_ram_addr(cpu_ram_addr), .cpu_ram_wr_data(cpu_ram_wr_data),
        .cpu_ram_wr_en(cpu_ram_wr_en), .ram_rd_data(ram_rd_data),
        .cpu_rst(cpu_rst), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
        .ram_wr_en(ram_wr_en), .busy(busy), .done(done), .mismatch(mismatch),
        .last_a(last_a), .last_b(last_b), .ok_count(ok_count),
        .err_count(err_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    // RAM: synchronous write, combinational read
    logic [W-1:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    assign ram_rd_data = mem[ram_addr];

    // CPU stub
    logic [2:0] stub_op;
    logic       corrupt, hang;
    int         cyc;
    logic [W-1:0]   sa, sb;
    logic [2*W-1:0] full;

    always @(posedge clk) begin
        if (cpu_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always_comb begin
        sa   = mem[0];
        sb   = mem[1];
        full = '0;
        case (stub_op)
            3'd0: full = {2'b00, sa + sb};
            3'd1: full = {2'b00, sa - sb};
            3'd2: full = {2'b00, ~(sa & sb)};
            3'd3: full = {2'b00, ~(sa | sb)};
            3'd4: full = {2'b00, sa ^ sb};
            3'd5: full = {2'b00, ~(sa ^ sb)};
            default: full = {2'b00, sa} * {2'b00, sb};
        endcase
        if (corrupt && sa == 2'd3 && sb == 2'd2) full[0] = ~full[0];
        cpu_ram_addr    = 8'h40;
        cpu_ram_wr_data = 2'(cyc);
        cpu_ram_wr_en   = 1'b0;
        rom_addr        = 8'h10;
        if (cyc == 1) begin
            cpu_ram_addr = 8'd2; cpu_ram_wr_data = full[1:0]; cpu_ram_wr_en = 1'b1;
        end else if (cyc == 2) begin
            cpu_ram_addr = 8'd3; cpu_ram_wr_data = full[3:2]; cpu_ram_wr_en = 1'b1;
        end
        if (cyc >= 5 && !hang) rom_addr = 8'h87;
    end

    // Monitor on the falling edge
    int done_cnt, mm_cnt, runlen, rmin, rmax;
    logic [W-1:0] mm_a, mm_b;

    always @(negedge clk) begin
        if (!rst && !cpu_rst) begin
            checks++;
            assert ({ram_addr, ram_wr_data, ram_wr_en} === {cpu_ram_addr, cpu_ram_wr_data, cpu_ram_wr_en})
            else begin
                errors++;
                $error("FAIL passthru: got %h/%h/%b expected %h/%h/%b", ram_addr, ram_wr_data,
                       ram_wr_en, cpu_ram_addr, cpu_ram_wr_data, cpu_ram_wr_en);
            end
        end
        if (done) done_cnt++;
        if (mismatch) begin
            mm_cnt++; mm_a = last_a; mm_b = last_b;
        end
        if (!cpu_rst) runlen++;
        else if (runlen != 0) begin
            if (runlen < rmin) rmin = runlen;
            if (runlen > rmax) rmax = runlen;
            runlen = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        done_cnt = 0; mm_cnt = 0; runlen = 0; rmin = 1000; rmax = 0;
        mm_a = '0; mm_b = '0;
    endtask

    // Called at posedge+1; returns at posedge+1
    task automatic pulse_start(input logic [2:0] m);
        start = 1'b1; mode = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 6000) begin
            @(posedge clk); n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic expect_counts(input string tag, input int ok, input int er, input int to);
        chk({tag, "_ok"}, 32'(ok_count), 32'(ok));
        chk({tag, "_err"}, 32'(err_count), 32'(er));
        chk({tag, "_to"}, 32'(timeout_count), 32'(to));
        chk({tag, "_done_pulses"}, 32'(done_cnt), 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 3'd0;
        stub_op = 3'd0; corrupt = 1'b0; hang = 1'b0;
        clr_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst", 32'(cpu_rst), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        chk("rst_ram_wr_en", 32'(ram_wr_en), 0);
        chk("rst_counts", {ok_count, err_count, timeout_count}, 0);
        chk("rst_last", {last_a, last_b}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Every non-reserved mode against a correct stub
        for (int m = 0; m < 6; m++) begin
            stub_op = 3'(m);
            clr_stats();
            pulse_start(3'(m));
            chk($sformatf("m%0d_busy", m), 32'(busy), 1);
            wait_done($sformatf("m%0d", m));
            expect_counts($sformatf("m%0d", m), 16, 0, 0);
            chk($sformatf("m%0d_mm", m), 32'(mm_cnt), 0);
            chk($sformatf("m%0d_last", m), {last_a, last_b}, 32'hF);
        end

        // Multiply with the (3,2) result corrupted
        stub_op = 3'd6; corrupt = 1'b1;
        clr_stats();
        pulse_start(3'd6);
        wait_done("mul");
        expect_counts("mul", 15, 1, 0);
        chk("mul_mm_pulses", 32'(mm_cnt), 1);
        chk("mul_mm_a", 32'(mm_a), 3);
        chk("mul_mm_b", 32'(mm_b), 2);
        corrupt = 1'b0;

        // CPU never finishes: every pair times out after TO cycles
        stub_op = 3'd0; hang = 1'b1;
        clr_stats();
        pulse_start(3'd0);
        wait_done("tmo");
        expect_counts("tmo", 0, 16, 16);
        chk("tmo_mm_pulses", 32'(mm_cnt), 16);
        chk("tmo_run_min", 32'(rmin), 32'(TO));
        chk("tmo_run_max", 32'(rmax), 32'(TO));
        hang = 1'b0;

        // Reset in WAIT_DONE aborts the sweep
        clr_stats();
        pulse_start(3'd0);
        begin
            int n = 0;
            while ((ok_count < 2 || cpu_rst) && n < 500) begin
                @(posedge clk); #1; n++;
            end
            chk("abort_reach_wait", 32'(n < 500), 1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_cpu_rst", 32'(cpu_rst), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_counts", {ok_count, err_count, timeout_count}, 0);
        chk("abort_ram_wr_en", 32'(ram_wr_en), 0);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 0);
        pulse_start(3'd0);
        wait_done("fresh");
        expect_counts("fresh", 16, 0, 0);

        // Reserved mode is ignored; counters hold
        pulse_start(3'd7);
        chk("m7_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("m7_busy_later", 32'(busy), 0);
        chk("m7_ok_hold", 32'(ok_count), 16);

        // A start while busy must not restart or change mode
        stub_op = 3'd0;
        clr_stats();
        pulse_start(3'd0);
        repeat (40) @(posedge clk);
        #1;
        pulse_start(3'd2);
        wait_done("busy_start");
        expect_counts("busy_start", 16, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
